// File: rtl/regfile_pkg.sv
// Shared sizing constants for the 32-entry register file.
package regfile_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_NUM_REGS   = 32;

    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [REGFILE_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/mux_32.sv
// 32-to-1 read multiplexer used for each register-file read port.
module mux_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data [32],
    input  logic [4:0]       i_sel,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/register_32.sv
// One storage register: WIDTH flops with load enable and async active-low clear.
module register_32 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Storage flops; clear wins over any load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile.sv
// 32 x DATA_WIDTH register file, r0 hardwired to zero, two async read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic [NUM_REGS-1:1]   w_wr_en;
    logic [DATA_WIDTH-1:0] w_mux_a;
    logic [DATA_WIDTH-1:0] w_mux_b;

    // One-hot write decoder gated by the write enable; index 0 has no storage.
    always_comb begin
        w_wr_en = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_wr_en[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_WIDTH'(i));
        end
    end

    assign w_regs[0] = '0;

    genvar gi;
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        register_32 #(.WIDTH(DATA_WIDTH)) u_reg (
            .i_clk   (clock),
            .i_rst_n (ctrl_reset_n),
            .i_en    (w_wr_en[gi]),
            .i_d     (data_writeReg),
            .o_q     (w_regs[gi])
        );
    end

    mux_32 #(.WIDTH(DATA_WIDTH)) u_mux_a (
        .i_data (w_regs),
        .i_sel  (ctrl_readRegA),
        .o_data (w_mux_a)
    );

    mux_32 #(.WIDTH(DATA_WIDTH)) u_mux_b (
        .i_data (w_regs),
        .i_sel  (ctrl_readRegB),
        .o_data (w_mux_b)
    );

`ifdef REGFILE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    assign w_byp_a = ctrl_reset_n && ctrl_writeEnable && (ctrl_writeReg != '0)
                     && (ctrl_writeReg == ctrl_readRegA);
    assign w_byp_b = ctrl_reset_n && ctrl_writeEnable && (ctrl_writeReg != '0)
                     && (ctrl_writeReg == ctrl_readRegB);

    // Forward in-flight write data so a same-cycle read sees the new value.
    always_comb begin
        if (w_byp_a) begin
            data_readRegA = data_writeReg;
        end else begin
            data_readRegA = w_mux_a;
        end
        if (w_byp_b) begin
            data_readRegB = data_writeReg;
        end else begin
            data_readRegB = w_mux_b;
        end
    end
`else
    assign data_readRegA = w_mux_a;
    assign data_readRegB = w_mux_b;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed literal checks plus randomized traffic
// compared every cycle against an array-based model.
module tb_regfile;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    logic [31:0] model [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    regfile dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read port must show given the current inputs and the model contents.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (ctrl_reset_n !== 1'b1) return 32'h0;
        if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
`endif
        return model[idx];
    endfunction

    always @(negedge clock) begin
        check("cycle_readA", data_readRegA, exp_read(ctrl_readRegA));
        check("cycle_readB", data_readRegB, exp_read(ctrl_readRegB));
    end

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, committing the pending write into the model.
    task automatic tick();
        @(posedge clock);
        if (ctrl_reset_n && ctrl_writeEnable && ctrl_writeReg != 5'd0)
            model[ctrl_writeReg] = data_writeReg;
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
    endtask

    initial begin
        clear_model();
        ctrl_reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
        tick();
        tick();
        check("reset_A", data_readRegA, 32'h0);
        check("reset_B", data_readRegB, 32'h0);
        ctrl_reset_n = 1'b1;
        tick();

        // Fill r1..r31 with i * 0x01010101.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
            tick();
        end
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check("fill_A", data_readRegA, 32'(i) * 32'h01010101);
            check("fill_B", data_readRegB, 32'(31 - i) * 32'h01010101);
            tick();
        end

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("r0_A", data_readRegA, 32'h0);
        check("r0_B", data_readRegB, 32'h0);

        drive(1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
        tick();
        check("we_off_r7", data_readRegA, 32'h07070707);

        drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_r9", data_readRegA, 32'hA5A5A5A5);
`else
        check("same_cycle_r9", data_readRegA, 32'h09090909);
`endif
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        check("after_edge_r9", data_readRegB, 32'hA5A5A5A5);

        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        #1;
        check("r5_written", data_readRegA, 32'hDEADBEEF);
        ctrl_reset_n = 1'b0;
        clear_model();
        #1;
        check("r5_async_clear_A", data_readRegA, 32'h0);
        check("r5_async_clear_B", data_readRegB, 32'h0);

        // Write edge while reset is held must be lost.
        drive(1'b1, 5'd3, 32'h00000055, 5'd3, 5'd3);
        tick();
        ctrl_reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        check("r3_reset_priority", data_readRegA, 32'h0);

        drive(1'b1, 5'd3, 32'h00000077, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
        #1;
        check("first_write_after_reset", data_readRegA, 32'h00000077);
        check("other_reg_cleared", data_readRegB, 32'h0);
        tick();

        for (int n = 0; n < 600; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 63) == 0) begin
                ctrl_reset_n = 1'b0;
                clear_model();
            end else begin
                ctrl_reset_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
